// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W     = 19;
    localparam int unsigned SRAM_DATA_W     = 16;
    localparam int unsigned WAIT_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase cycle counter: clear, load, free increment and terminal-count compare.
module sram_phase_timer #(
    parameter int unsigned WAIT_CYCLES = 2,
    localparam int unsigned CW         = $clog2(WAIT_CYCLES + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic [CW-1:0] i_tc_val,
    output logic [CW-1:0] o_cnt,
    output logic          o_tc_c
);

    logic [CW-1:0] r_cnt;

    // Counter register; clear has priority over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_tc_c = (r_cnt == i_tc_val);

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit request port to 16-bit asynchronous SRAM controller with registered strobes.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic [3:0]             be,
    output logic                   ready,
    output logic                   done,
    output logic [31:0]            rdata,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_ub,
    output logic                   sram_lb,
    output logic [SRAM_DATA_W-1:0] sram_data_o,
    output logic                   sram_data_oe,
    input  logic [SRAM_DATA_W-1:0] sram_data_i
);

    localparam int unsigned CW = $clog2(WAIT_CYCLES + 2);
    localparam logic [CW-1:0] RD_LAST = CW'(WAIT_CYCLES);
    localparam logic [CW-1:0] WR_LAST = CW'(WAIT_CYCLES + 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [17:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [3:0]             r_be;

    logic                   r_ready;
    logic                   r_done;
    logic [31:0]            r_rdata;
    logic [SRAM_ADDR_W-1:0] r_sram_addr;
    logic                   r_ce_n;
    logic                   r_oe_n;
    logic                   r_we_n;
    logic                   r_ub;
    logic                   r_lb;
    logic [SRAM_DATA_W-1:0] r_data_o;
    logic                   r_data_oe;

    logic                   w_accept;
    logic [17:0]            w_addr_src;
    logic [31:0]            w_wdata_src;
    logic [3:0]             w_be_src;
    logic [CW-1:0]          w_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [CW-1:0]          w_tc_val;
    logic                   w_tc;
    logic                   w_clr;
    logic                   w_we_low;

    logic                   w_ready_nxt;
    logic                   w_done_nxt;
    logic [SRAM_ADDR_W-1:0] w_sram_addr_nxt;
    logic                   w_ce_n_nxt;
    logic                   w_oe_n_nxt;
    logic                   w_we_n_nxt;
    logic                   w_ub_nxt;
    logic                   w_lb_nxt;
    logic [SRAM_DATA_W-1:0] w_data_o_nxt;
    logic                   w_data_oe_nxt;

    // Byte-offset and upper address bits are outside the 1 MB SRAM window.
    logic w_unused;
    assign w_unused = ^{addr[31:20], addr[1:0]};

    // On the accept cycle the request fields come straight from the port.
    assign w_accept    = (r_state == S_IDLE) && req;
    assign w_addr_src  = w_accept ? addr[19:2] : r_addr;
    assign w_wdata_src = w_accept ? wdata      : r_wdata;
    assign w_be_src    = w_accept ? be         : r_be;

    assign w_tc_val = ((r_state == S_RD_LO) || (r_state == S_RD_HI)) ? RD_LAST : WR_LAST;

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_tc_val   (w_tc_val),
        .o_cnt      (w_cnt),
        .o_tc_c     (w_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a phase ends when the timer reaches its terminal count.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (!we) begin
                        w_state_nxt = S_RD_LO;
                    end else if (be[1:0] != 2'b00) begin
                        w_state_nxt = S_WR_LO;
                    end else if (be[3:2] != 2'b00) begin
                        w_state_nxt = S_WR_HI;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_RD_LO: if (w_tc) w_state_nxt = S_RD_HI;
            S_RD_HI: if (w_tc) w_state_nxt = S_DONE;
            S_WR_LO: begin
                if (w_tc) w_state_nxt = (r_be[3:2] != 2'b00) ? S_WR_HI : S_DONE;
            end
            S_WR_HI: if (w_tc) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The counter restarts on every phase entry and rests at zero while idle.
    assign w_clr     = (w_state_nxt != r_state) || (w_state_nxt == S_IDLE);
    assign w_cnt_nxt = w_clr ? '0 : (w_cnt + CW'(1));
    assign w_we_low  = (w_cnt_nxt != '0) && (w_cnt_nxt <= RD_LAST);

    // Output values for the coming cycle; address and data hold when idle.
    always_comb begin
        w_ready_nxt     = (w_state_nxt == S_IDLE);
        w_done_nxt      = 1'b0;
        w_sram_addr_nxt = r_sram_addr;
        w_ce_n_nxt      = 1'b1;
        w_oe_n_nxt      = 1'b1;
        w_we_n_nxt      = 1'b1;
        w_ub_nxt        = 1'b1;
        w_lb_nxt        = 1'b1;
        w_data_o_nxt    = r_data_o;
        w_data_oe_nxt   = 1'b0;
        case (w_state_nxt)
            S_RD_LO, S_RD_HI: begin
                w_sram_addr_nxt = {w_addr_src, (w_state_nxt == S_RD_HI)};
                w_ce_n_nxt      = 1'b0;
                w_oe_n_nxt      = 1'b0;
                w_ub_nxt        = 1'b0;
                w_lb_nxt        = 1'b0;
            end
            S_WR_LO: begin
                w_sram_addr_nxt = {w_addr_src, 1'b0};
                w_ce_n_nxt      = 1'b0;
                w_we_n_nxt      = !w_we_low;
                w_lb_nxt        = !w_be_src[0];
                w_ub_nxt        = !w_be_src[1];
                w_data_o_nxt    = w_wdata_src[15:0];
                w_data_oe_nxt   = 1'b1;
            end
            S_WR_HI: begin
                w_sram_addr_nxt = {w_addr_src, 1'b1};
                w_ce_n_nxt      = 1'b0;
                w_we_n_nxt      = !w_we_low;
                w_lb_nxt        = !w_be_src[2];
                w_ub_nxt        = !w_be_src[3];
                w_data_o_nxt    = w_wdata_src[31:16];
                w_data_oe_nxt   = 1'b1;
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Output registers, request capture and read-data assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub        <= 1'b1;
            r_lb        <= 1'b1;
            r_data_o    <= '0;
            r_data_oe   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr[19:2];
                r_wdata <= wdata;
                r_be    <= be;
            end
            if ((r_state == S_RD_LO) && w_tc) r_rdata[15:0]  <= sram_data_i;
            if ((r_state == S_RD_HI) && w_tc) r_rdata[31:16] <= sram_data_i;
            r_ready     <= w_ready_nxt;
            r_done      <= w_done_nxt;
            r_sram_addr <= w_sram_addr_nxt;
            r_ce_n      <= w_ce_n_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_we_n      <= w_we_n_nxt;
            r_ub        <= w_ub_nxt;
            r_lb        <= w_lb_nxt;
            r_data_o    <= w_data_o_nxt;
            r_data_oe   <= w_data_oe_nxt;
        end
    end

    assign ready        = r_ready;
    assign done         = r_done;
    assign rdata        = r_rdata;
    assign sram_addr    = r_sram_addr;
    assign sram_ce_n    = r_ce_n;
    assign sram_oe_n    = r_oe_n;
    assign sram_we_n    = r_we_n;
    assign sram_ub      = r_ub;
    assign sram_lb      = r_lb;
    assign sram_data_o  = r_data_o;
    assign sram_data_oe = r_data_oe;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl against a behavioural byte-maskable SRAM.
module tb_sram_ctrl;

    localparam int unsigned W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic [18:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub, sram_lb;
    logic [15:0] sram_data_o;
    logic        sram_data_oe;
    logic [15:0] sram_data_i;

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .be           (be),
        .ready        (ready),
        .done         (done),
        .rdata        (rdata),
        .sram_addr    (sram_addr),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_ub      (sram_ub),
        .sram_lb      (sram_lb),
        .sram_data_o  (sram_data_o),
        .sram_data_oe (sram_data_oe),
        .sram_data_i  (sram_data_i)
    );

    // Behavioural asynchronous SRAM: writes while ce_n and we_n are low.
    logic [15:0] mem [0:2047];
    assign sram_data_i = (!sram_ce_n && !sram_oe_n && !sram_data_oe) ? mem[sram_addr[10:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb) mem[sram_addr[10:0]][7:0]  <= sram_data_o[7:0];
            if (!sram_ub) mem[sram_addr[10:0]][15:8] <= sram_data_o[15:8];
        end
    end

    // Bus protocol monitor sampled mid-cycle.
    logic [36:0] wr_q[$];
    int          run_q[$];
    int          run_len   = 0;
    int          viol      = 0;
    int          ce_low    = 0;
    int          n_acc     = 0;
    logic        prev_we_n = 1'b1;
    logic        prev_rst  = 1'b1;
    logic [18:0] prev_addr = '0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (!sram_ce_n) ce_low <= ce_low + 1;
        if (!sram_we_n) begin
            run_len <= run_len + 1;
            if (prev_we_n) wr_q.push_back({sram_addr, sram_data_o, sram_ub, sram_lb});
        end else if (!prev_we_n) begin
            run_q.push_back(run_len);
            run_len <= 0;
        end
        if ((!sram_oe_n && sram_data_oe) || (!sram_we_n && !sram_data_oe) ||
            (!prev_rst && (!sram_we_n || !prev_we_n) &&
             ((sram_addr != prev_addr) || (sram_data_o != prev_data))))
            viol <= viol + 1;
        prev_we_n <= sram_we_n;
        prev_rst  <= rst;
        prev_addr <= sram_addr;
        prev_data <= sram_data_o;
    end

    always @(posedge clk) begin
        if (!rst && req && ready) n_acc <= n_acc + 1;
    end

    // Scoreboard and reference word memory.
    typedef struct packed {
        logic        w;
        logic [31:0] rd;
        logic [31:0] lat;
    } sb_t;
    sb_t         sb_q[$];
    logic [31:0] ref_mem [0:1023];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one access, push its expectation, wait for done and compare.
    task automatic do_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic hold);
        sb_t exp;
        sb_t got_exp;
        int  cyc;
        exp.w  = w;
        exp.rd = ref_mem[a[11:2]];
        if (!w) exp.lat = 32'(2 * (W + 1) + 1);
        else if (b[1:0] != 2'b00 && b[3:2] != 2'b00) exp.lat = 32'(2 * (W + 2) + 1);
        else if (b != 4'b0000) exp.lat = 32'((W + 2) + 1);
        else exp.lat = 32'd1;
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) ref_mem[a[11:2]][i*8 +: 8] = d[i*8 +: 8];
        end
        sb_q.push_back(exp);
        cyc = 0;
        while (!ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_req", ready, 1);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 200);
        req = 1'b0;
        got_exp = sb_q.pop_front();
        check(w ? "wr_latency" : "rd_latency", 64'(cyc), 64'(got_exp.lat));
        if (!got_exp.w) check("rdata", rdata, got_exp.rd);
    endtask

    int          ce0, acc0, dn;
    logic [36:0] e;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h1004; wdata = 32'hFFFF_FFFF; be = 4'hF;

        // Reset held with req asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_done", {ready, done}, 2'b10);
        check("rst_rdata", rdata, 32'h0);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub, sram_lb}, 5'b11111);
        check("rst_bus", {sram_addr, sram_data_o, sram_data_oe}, 36'h0);
        req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready, 1);

        // Full-word write.
        wr_q.delete(); run_q.delete();
        do_acc(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        check("wr_phases", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            e = wr_q.pop_front();
            check("wr_lo_bus", e, {19'h00802, 16'hBEEF, 1'b0, 1'b0});
            e = wr_q.pop_front();
            check("wr_hi_bus", e, {19'h00803, 16'hDEAD, 1'b0, 1'b0});
        end
        check("we_runs", run_q.size(), 2);
        while (run_q.size() > 0) check("we_low_len", run_q.pop_front(), W);

        // Read back.
        do_acc(1'b0, 32'h0000_1004, 32'h0, 4'b0000, 1'b0);

        // Single-byte write touching only the high half.
        wr_q.delete(); run_q.delete();
        do_acc(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0100, 1'b0);
        check("byte_phases", wr_q.size(), 1);
        if (wr_q.size() == 1) begin
            e = wr_q.pop_front();
            check("byte_bus", e, {19'h00803, 16'hDEAD, 1'b1, 1'b0});
        end
        check("byte_we_len", run_q.size() == 1 ? run_q.pop_front() : -1, W);
        do_acc(1'b0, 32'h0000_1004, 32'h0, 4'b0000, 1'b0);
        do_acc(1'b1, 32'h0000_1004, 32'h1234_5678, 4'b0100, 1'b0);
        do_acc(1'b0, 32'h0000_1004, 32'h0, 4'b0000, 1'b0);
        check("byte2_ref", ref_mem[32'h1004 >> 2], 32'hDE34_BEEF);

        // Empty byte mask.
        ce0 = ce_low;
        do_acc(1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'b0000, 1'b0);
        @(negedge clk);
        check("be0_no_ce", ce_low - ce0, 0);

        // Random traffic over a small fully initialised window.
        for (int i = 0; i < 8; i++)
            do_acc(1'b1, 32'h0000_0100 + 32'(i * 4), $urandom, 4'hF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            ra = 32'h0000_0100 + 32'($urandom_range(0, 7) * 4);
            do_acc(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end

        // Reset in cycle 3 of a full write.
        while (!ready) @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h0000_2000; wdata = 32'h5555_AAAA; be = 4'hF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_strobes", {sram_ce_n, sram_we_n, sram_data_oe}, 3'b110);
        check("midrst_ready_done", {ready, done}, 2'b10);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("midrst_no_done", dn, 0);

        // req held through a busy read is accepted once.
        acc0 = n_acc;
        do_acc(1'b0, 32'h0000_1004, 32'h0, 4'b0000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("held_req_accepts", n_acc - acc0, 1);
        do_acc(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1'b0);

        check("protocol_violations", viol, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
